pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have `stallreq_if`, `stallreq_id`, `stallreq_ex` and `stallreq_mem`, each input, 1 bit: per-stage stall requests.
REQ-004 SHALL have `branch_flag`, input, 1 bit, and `branch_target`, input, 32 bits: taken-branch redirect from EX.
REQ-005 SHALL have `excp_flag`, input, 1 bit, and `excp_vec`, input, 32 bits: exception redirect from MEM.
REQ-006 SHALL have `stall`, output, 6 bits: per-stage stall vector.
- Bit 0 = PC, bit 1 = IF, bit 2 = ID, bit 3 = EX, bit 4 = MEM, bit 5 = WB.
- Downstream registers insert a bubble where stall[i]=1 and stall[i+1]=0.
REQ-007 SHALL have `flushreq`, output, 1 bit: clears the IF/ID, ID/EX and EX/MEM registers.
REQ-008 SHALL have `new_pc_valid`, output, 1 bit, and `new_pc`, output, 32 bits: PC load strobe and value.
REQ-009 SHALL have `stall_cnt`, output, 32 bits, and `redir_cnt`, output, 16 bits: performance counters (see Configuration).

Function
REQ-010 All outputs SHALL be combinational from the inputs and the registered state: zero-cycle latency. Only the FSM, `pend_pc` and the counters are registered.
REQ-011 Outside a redirect, `stall` SHALL follow the deepest active request:
- mem: 011111
- else ex: 001111
- else id: 000111
- else if: 000011
- else: 000000
REQ-012 The FSM SHALL have two states, RUN and PEND; reset state is RUN.
REQ-013 In RUN, an exception SHALL be accepted only when excp_flag=1 and stallreq_mem=0. The redirect target is `excp_vec`.
REQ-014 In RUN, a branch SHALL be accepted only when branch_flag=1, there is no accepted exception, and stallreq_ex=0 and stallreq_mem=0. The redirect target is `branch_target`.
REQ-015 An exception SHALL override a branch in the same cycle.
REQ-016 On an accepted redirect in RUN with stallreq_if=0:
- flushreq=1, new_pc_valid=1, new_pc=target, stall=000000;
- the FSM stays in RUN.
REQ-017 On an accepted redirect in RUN with stallreq_if=1:
- flushreq=1, new_pc_valid=0, stall=000011;
- pend_pc<=target and the FSM goes to PEND.
REQ-018 In PEND, every cycle SHALL drive flushreq=1 and ignore branch_flag.
REQ-019 In PEND with stallreq_if=1:
- stall=000011 and new_pc_valid=0;
- excp_flag=1 overwrites pend_pc with excp_vec.
REQ-020 In PEND with stallreq_if=0:
- new_pc_valid=1, stall=000000, return to RUN;
- new_pc=excp_vec if excp_flag=1, else pend_pc.
REQ-021 When new_pc_valid=0, new_pc SHALL be 0.
REQ-022 A branch or exception that is not accepted SHALL produce no side effect; its requester holds the request.

Reset
REQ-023 While rst=1, the outputs SHALL be: stall=000000, flushreq=0, new_pc_valid=0, new_pc=0.
REQ-024 On a clock edge with rst=1, the block SHALL set FSM=RUN, pend_pc=0, stall_cnt=0 and redir_cnt=0.
REQ-025 Reset during PEND SHALL drop the pending target; no redirect is issued after reset.

Configuration
REQ-026 The feature is controlled by the macro `PIPE_CTRL_PERF_EN`.
REQ-027 With `PIPE_CTRL_PERF_EN` defined:
- stall_cnt SHALL increment every cycle with stall[0]=1 and wrap at 2^32;
- redir_cnt SHALL increment once per new_pc_valid=1 cycle and wrap at 2^16.
REQ-028 Without `PIPE_CTRL_PERF_EN`, stall_cnt and redir_cnt SHALL be tied to 0 and no counter registers are built.

Verification
REQ-029 Stall encoding: stallreq_id=1 and stallreq_mem=1 together -> stall=011111, flushreq=0.
REQ-030 Plain branch: branch_flag=1, branch_target=0x00000040, no stalls -> same cycle flushreq=1, new_pc_valid=1, new_pc=0x00000040; FSM stays RUN.
REQ-031 Blocked branch: branch_flag=1, target 0x80, with stallreq_ex=1 -> stall=001111, flushreq=0, new_pc_valid=0, until stallreq_ex falls.
REQ-032 Pending redirect: excp_vec=0x100 accepted while stallreq_if=1 held 3 cycles -> flushreq=1 and stall=000011 for 3 cycles. The cycle stallreq_if falls: new_pc_valid=1, new_pc=0x100.
REQ-033 Priority and overwrite:
- excp_flag and branch_flag in the same cycle -> new_pc=excp_vec.
- In PEND with pend_pc=0x80, excp_flag=1 with excp_vec=0x200 -> final new_pc=0x200.
REQ-034 Reset in PEND, then perf counters:
- rst during PEND -> next cycle state RUN, no new_pc_valid.
- With `PIPE_CTRL_PERF_EN`: 5 stalled cycles plus 2 redirects -> stall_cnt=5, redir_cnt=2. Without the macro, both read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, flush and PC redirect (optional perf counters via PIPE_CTRL_PERF_EN).
// Latency: all outputs combinational from inputs and registered state (zero cycles).
// Backpressure: redirects are deferred in PEND while IF stalls; unaccepted branch/exception requests are held by the requester.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        excp_flag,
  input  logic [31:0] excp_vec,
  output logic [5:0]  stall,
  output logic        flushreq,
  output logic        new_pc_valid,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic [15:0] redir_cnt
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t      state;
  logic [31:0] pend_pc;

  logic        excp_acc;
  logic        br_acc;
  logic        redir_acc;
  logic [31:0] redir_tgt;
  logic [5:0]  stall_base;

  // Redirect acceptance: exception wins over branch; neither may be taken while the stage behind it stalls.
  always_comb begin
    excp_acc  = (state == RUN) && excp_flag && !stallreq_mem;
    br_acc    = (state == RUN) && branch_flag && !excp_acc && !stallreq_ex && !stallreq_mem;
    redir_acc = excp_acc || br_acc;
    redir_tgt = excp_acc ? excp_vec : branch_target;
  end

  // Stall vector from the deepest stalling stage; everything upstream of it freezes too.
  always_comb begin
    if (stallreq_mem)      stall_base = 6'b011111;
    else if (stallreq_ex)  stall_base = 6'b001111;
    else if (stallreq_id)  stall_base = 6'b000111;
    else if (stallreq_if)  stall_base = 6'b000011;
    else                   stall_base = 6'b000000;
  end

  // Output decode: a redirect overrides the normal stall vector; if IF cannot take the new PC yet, hold PC/IF and keep flushing.
  always_comb begin
    stall        = stall_base;
    flushreq     = 1'b0;
    new_pc_valid = 1'b0;
    new_pc       = 32'h0;
    if (rst) begin
      stall = 6'b000000;
    end else if (state == PEND) begin
      flushreq = 1'b1;
      if (stallreq_if) begin
        stall = 6'b000011;
      end else begin
        stall        = 6'b000000;
        new_pc_valid = 1'b1;
        new_pc       = excp_flag ? excp_vec : pend_pc;
      end
    end else if (redir_acc) begin
      flushreq = 1'b1;
      if (stallreq_if) begin
        stall = 6'b000011;
      end else begin
        stall        = 6'b000000;
        new_pc_valid = 1'b1;
        new_pc       = redir_tgt;
      end
    end
  end

  // FSM and pending target: park the redirect target until IF is free; a late exception replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pend_pc <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redir_acc && stallreq_if) begin
            pend_pc <= redir_tgt;
            state   <= PEND;
          end
        end
        PEND: begin
          if (stallreq_if) begin
            if (excp_flag) pend_pc <= excp_vec;
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] redir_cnt_q;

  // Performance counters: PC-stalled cycles and issued redirects, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
      redir_cnt_q <= 16'h0;
    end else begin
      if (stall[0])     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (new_pc_valid) redir_cnt_q <= redir_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;
`else
  assign stall_cnt = 32'h0;
  assign redir_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus a randomized run against a behavioural model.
// Latency: outputs are compared every cycle on the falling clock edge.
// Backpressure: random stall requests exercise deferred redirects and blocked branches.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        excp_flag;
  logic [31:0] excp_vec;
  logic [5:0]  stall;
  logic        flushreq;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic [15:0] redir_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .excp_flag     (excp_flag),
    .excp_vec      (excp_vec),
    .stall         (stall),
    .flushreq      (flushreq),
    .new_pc_valid  (new_pc_valid),
    .new_pc        (new_pc),
    .stall_cnt     (stall_cnt),
    .redir_cnt     (redir_cnt)
  );

  // ---------------- behavioural model ----------------
  // Model state: "is a redirect waiting for IF" and the address it will go to.
  bit          m_waiting = 1'b0;
  logic [31:0] m_dest    = 32'h0;
  logic [31:0] m_scnt    = 32'h0;
  logic [15:0] m_rcnt    = 16'h0;

  logic [5:0]  e_stall;
  logic        e_flush, e_npv;
  logic [31:0] e_pc;

  // Expected outputs from the rules: stall depth = deepest requesting stage, redirect overrides it.
  always_comb begin
    int          depth;
    bit          want;
    logic [31:0] dest;
    depth = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    e_stall = 6'((1 << depth) - 1);
    e_flush = 1'b0;
    e_npv   = 1'b0;
    e_pc    = 32'h0;
    want    = 1'b0;
    dest    = 32'h0;
    if (m_waiting) begin
      want = 1'b1;
      dest = excp_flag ? excp_vec : m_dest;
    end else if (excp_flag && !stallreq_mem) begin
      want = 1'b1;
      dest = excp_vec;
    end else if (branch_flag && !stallreq_ex && !stallreq_mem) begin
      want = 1'b1;
      dest = branch_target;
    end
    if (rst) begin
      e_stall = 6'd0;
    end else if (want) begin
      e_flush = 1'b1;
      e_stall = stallreq_if ? 6'b000011 : 6'b000000;
      if (!stallreq_if) begin
        e_npv = 1'b1;
        e_pc  = dest;
      end
    end
  end

  // Model state advance.
  always @(posedge clk) begin
    if (rst) begin
      m_waiting = 1'b0;
      m_dest    = 32'h0;
      m_scnt    = 32'h0;
      m_rcnt    = 16'h0;
    end else begin
      m_scnt = m_scnt + 32'(e_stall[0]);
      m_rcnt = m_rcnt + 16'(e_npv);
      if (e_flush && stallreq_if) begin
        // redirect stays parked; the freshest target is the one that will win
        if (!m_waiting) m_dest = (excp_flag && !stallreq_mem) ? excp_vec : branch_target;
        else if (excp_flag) m_dest = excp_vec;
        m_waiting = 1'b1;
      end else begin
        m_waiting = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("stall",        32'(stall),        32'(e_stall));
    chk("flushreq",     32'(flushreq),     32'(e_flush));
    chk("new_pc_valid", 32'(new_pc_valid), 32'(e_npv));
    chk("new_pc",       new_pc,            e_pc);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt",    stall_cnt,         m_scnt);
    chk("redir_cnt",    32'(redir_cnt),    32'(m_rcnt));
`else
    chk("stall_cnt",    stall_cnt,         32'h0);
    chk("redir_cnt",    32'(redir_cnt),    32'h0);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    branch_flag = 0; branch_target = 32'h0; excp_flag = 0; excp_vec = 32'h0;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input logic [5:0] s, input logic f, input logic v, input logic [31:0] pc);
    chk({name, ".stall"}, 32'(stall),        32'(s));
    chk({name, ".flush"}, 32'(flushreq),     32'(f));
    chk({name, ".npv"},   32'(new_pc_valid), 32'(v));
    chk({name, ".pc"},    new_pc,            pc);
  endtask

  initial begin
    idle();
    rst = 1;
    // reset holds outputs quiet even with requests active
    branch_flag = 1; branch_target = 32'h44; stallreq_ex = 1;
    look(); lit("reset", 6'b000000, 0, 0, 32'h0);
    tick(); tick();
    rst = 0; idle();

    // id + mem stall
    stallreq_id = 1; stallreq_mem = 1;
    look(); lit("id_mem", 6'b011111, 0, 0, 32'h0);
    tick(); idle();

    // plain branch
    branch_flag = 1; branch_target = 32'h40;
    look(); lit("branch", 6'b000000, 1, 1, 32'h40);
    tick(); idle();
    look(); lit("branch_after", 6'b000000, 0, 0, 32'h0);
    tick();

    // blocked branch until ex stall drops
    branch_flag = 1; branch_target = 32'h80; stallreq_ex = 1;
    for (int i = 0; i < 2; i++) begin
      look(); lit("blocked", 6'b001111, 0, 0, 32'h0);
      tick();
    end
    stallreq_ex = 0;
    look(); lit("unblocked", 6'b000000, 1, 1, 32'h80);
    tick(); idle();

    // exception accepted while IF stalls for 3 cycles
    stallreq_if = 1; excp_flag = 1; excp_vec = 32'h100;
    look(); lit("pend0", 6'b000011, 1, 0, 32'h0);
    tick(); excp_flag = 0; excp_vec = 32'h0;
    for (int i = 1; i < 3; i++) begin
      look(); lit("pend", 6'b000011, 1, 0, 32'h0);
      tick();
    end
    stallreq_if = 0;
    look(); lit("pend_out", 6'b000000, 1, 1, 32'h100);
    tick(); idle();

    // exception beats branch in the same cycle
    excp_flag = 1; excp_vec = 32'h200; branch_flag = 1; branch_target = 32'h300;
    look(); lit("prio", 6'b000000, 1, 1, 32'h200);
    tick(); idle();

    // pending branch target overwritten by exception
    branch_flag = 1; branch_target = 32'h80; stallreq_if = 1;
    look(); lit("ovw0", 6'b000011, 1, 0, 32'h0);
    tick(); branch_flag = 0;
    excp_flag = 1; excp_vec = 32'h200;
    look(); lit("ovw1", 6'b000011, 1, 0, 32'h0);
    tick(); excp_flag = 0; excp_vec = 32'h0; stallreq_if = 0;
    look(); lit("ovw_out", 6'b000000, 1, 1, 32'h200);
    tick(); idle();

    // reset while pending drops the target
    branch_flag = 1; branch_target = 32'h500; stallreq_if = 1;
    tick(); idle(); stallreq_if = 1;
    rst = 1;
    look(); lit("rst_pend", 6'b000000, 0, 0, 32'h0);
    tick(); rst = 0; idle();
    look(); lit("after_rst", 6'b000000, 0, 0, 32'h0);
    tick();

    // perf counters: 5 stalled cycles then 2 redirects
    rst = 1; tick(); rst = 0;
    stallreq_if = 1;
    for (int i = 0; i < 5; i++) tick();
    idle(); branch_flag = 1; branch_target = 32'h10;
    tick(); branch_target = 32'h20;
    tick(); idle();
    look();
`ifdef PIPE_CTRL_PERF_EN
    chk("perf.stall_cnt", stall_cnt, 32'd5);
    chk("perf.redir_cnt", 32'(redir_cnt), 32'd2);
`else
    chk("perf.stall_cnt", stall_cnt, 32'd0);
    chk("perf.redir_cnt", 32'(redir_cnt), 32'd0);
`endif
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      stallreq_if   = ($urandom_range(0, 2) == 0);
      stallreq_id   = ($urandom_range(0, 5) == 0);
      stallreq_ex   = ($urandom_range(0, 5) == 0);
      stallreq_mem  = ($urandom_range(0, 6) == 0);
      branch_flag   = ($urandom_range(0, 2) == 0);
      branch_target = $urandom;
      excp_flag     = ($urandom_range(0, 4) == 0);
      excp_vec      = $urandom;
      tick();
    end
    rst = 0; idle();
    look();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
